mem_access_unit: RTL

//  Load/store sequencer between the execute stage and data_memory.

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_access_unit_rmw_alu.sv | 33 +++
 rtl/mem_access_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the request opcode encodings, the FSM state type and a few opcode
// classification helpers used by the top level and the RMW ALU.
package mem_access_unit_pkg;

    localparam int MAU_OP_W = 3;

    localparam logic [MAU_OP_W-1:0] MAU_OP_LD  = 3'd0;
    localparam logic [MAU_OP_W-1:0] MAU_OP_ST  = 3'd1;
    localparam logic [MAU_OP_W-1:0] MAU_OP_AND = 3'd2;
    localparam logic [MAU_OP_W-1:0] MAU_OP_OR  = 3'd3;
    localparam logic [MAU_OP_W-1:0] MAU_OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        MAU_S_IDLE  = 2'd0,
        MAU_S_READ  = 2'd1,
        MAU_S_WRITE = 2'd2,
        MAU_S_RESP  = 2'd3
    } mau_state_t;

    function automatic logic op_is_legal(input logic [MAU_OP_W-1:0] op);
        return (op <= MAU_OP_XOR);
    endfunction

endpackage

// File: rtl/mem_access_unit_rmw_alu.sv
// mau_rmw_alu: combinational write-back word generator.
// Ports:
//   op       in   opcode of the request in flight
//   old_word in   word read from memory (rdata_q)
//   operand  in   request data (data_q)
//   new_word out  word to write back (operand for ST, old OP operand for RMW)
//   legal    out  opcode is one of the defined operations
module mau_rmw_alu
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [MAU_OP_W-1:0]   op,
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] new_word,
    output logic                  legal
);

    always_comb begin
        new_word = '0;
        legal    = op_is_legal(op);
        case (op)
            MAU_OP_LD:  new_word = old_word;
            MAU_OP_ST:  new_word = operand;
            MAU_OP_AND: new_word = old_word & operand;
            MAU_OP_OR:  new_word = old_word | operand;
            MAU_OP_XOR: new_word = old_word ^ operand;
            default:    new_word = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store/fetch-and-op sequencer in front of data_memory.
// Takes one request at a time over valid/ready, drives the memory port from
// state and capture registers only, and returns a one-cycle response pulse
// for loads, RMW ops (pre-modification value) and illegal opcodes.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/req_addr/req_data       request fields
//   rsp_valid/rsp_data/rsp_err     registered response pulse
//   dm_wr/dm_address/dm_data_in    to data_memory (sampled at posedge)
//   dm_data_out                    from data_memory (combinational read)
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory word at addr_q captured into rdata_q
// WRITE | dm_wr asserted with store data or RMW result
// RESP  | response pulse presented
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MAU_OP_W-1:0]      req_op,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err,
    output logic                     dm_wr,
    output logic [ADDRESS_WIDTH-1:0] dm_address,
    output logic [DATA_WIDTH-1:0]    dm_data_in,
    input  logic [DATA_WIDTH-1:0]    dm_data_out
);

    mau_state_t               state, next_state;
    logic [MAU_OP_W-1:0]      op_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic [DATA_WIDTH-1:0]    wb_word;
    logic                     wb_legal;
    logic                     accept;

    assign req_ready = (state == MAU_S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    mau_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op       (op_q),
        .old_word (rdata_q),
        .operand  (data_q),
        .new_word (wb_word),
        .legal    (wb_legal)
    );

    always_comb begin
        next_state = state;
        case (state)
            MAU_S_IDLE: begin
                if (accept) begin
                    if (!op_is_legal(req_op))
                        next_state = MAU_S_RESP;
                    else if (req_op == MAU_OP_ST)
                        next_state = MAU_S_WRITE;
                    else
                        next_state = MAU_S_READ;
                end
            end
            MAU_S_READ:  next_state = (op_q == MAU_OP_LD) ? MAU_S_RESP : MAU_S_WRITE;
            MAU_S_WRITE: next_state = (op_q == MAU_OP_ST) ? MAU_S_IDLE : MAU_S_RESP;
            MAU_S_RESP:  next_state = MAU_S_IDLE;
            default:     next_state = MAU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MAU_S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q   <= req_op;
                addr_q <= req_addr;
                data_q <= req_data;
            end
            if (state == MAU_S_READ)
                rdata_q <= dm_data_out;

            // Response registers are loaded on the edge that enters RESP so
            // they line up with the RESP cycle. Entry from IDLE only happens
            // for an illegal opcode; from READ the load value is still on
            // dm_data_out; from WRITE the RMW old value sits in rdata_q.
            rsp_valid_q <= (next_state == MAU_S_RESP);
            rsp_err_q   <= (next_state == MAU_S_RESP) && (state == MAU_S_IDLE);
            if (next_state == MAU_S_RESP && state == MAU_S_READ)
                rsp_data_q <= dm_data_out;
            else if (next_state == MAU_S_RESP && state == MAU_S_WRITE)
                rsp_data_q <= rdata_q;
            else
                rsp_data_q <= '0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;

    // Reset gates the write strobe directly so an edge with rst high never
    // commits, even when the FSM is parked in WRITE.
    assign dm_wr      = (state == MAU_S_WRITE) && wb_legal && !rst;
    assign dm_address = addr_q;
    assign dm_data_in = (state == MAU_S_WRITE) ? wb_word : '0;

endmodule
